// File: rtl/user_core_nmi_shim_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : user_core_shim_pkg
//  Purpose  : Shared types and widths for the user-core NMI shim: the shim
//             FSM state enum, NMI bus widths, fault counter width and a
//             word-alignment helper.
//  Revision : 1.0  initial release
// ============================================================================
package user_core_shim_pkg;

    localparam int NMI_AW      = 32;
    localparam int NMI_DW      = 32;
    localparam int NMI_SW      = 4;
    localparam int FAULT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        FAULT = 2'd3
    } shim_state_e;

    // Drop the byte offset so the bus only ever sees word addresses.
    function automatic logic [NMI_AW-1:0] word_align(input logic [NMI_AW-1:0] addr);
        return {addr[NMI_AW-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/user_core_nmi_shim_if.sv
`default_nettype none
// ============================================================================
//  Module   : user_core_nmi_shim_if
//  Purpose  : Native memory interface (NMI) request/response bundle.
//  Signals  : valid  - request valid (master -> slave)
//             ready  - one-cycle completion (slave -> master)
//             addr   - byte address
//             wstrb  - write strobes, 0 = read
//             wdata  - write data
//             rdata  - read data, qualified by ready
//  Modports : master (issues requests), slave (answers requests)
//  Revision : 1.0  initial release
// ============================================================================
interface user_core_nmi_shim_if;
    import user_core_shim_pkg::*;

    logic              valid;
    logic              ready;
    logic [NMI_AW-1:0] addr;
    logic [NMI_SW-1:0] wstrb;
    logic [NMI_DW-1:0] wdata;
    logic [NMI_DW-1:0] rdata;

    modport master (
        output valid, addr, wstrb, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wstrb, wdata,
        output ready, rdata
    );

endinterface
`default_nettype wire

// File: rtl/user_core_nmi_shim_irq_cond.sv
`default_nettype none
// ============================================================================
//  Module   : user_core_irq_cond
//  Purpose  : Per-line interrupt conditioning. Optional two-flop
//             synchroniser, then each line is either passed as a level or
//             turned into a one-cycle pulse on its rising edge.
//  Ports    : clk_i   - clock
//             rst_i   - synchronous active-high reset
//             irq_in  - raw interrupt lines (NUM_IRQ)
//             irq_out - conditioned interrupt lines (NUM_IRQ)
//  Revision : 1.0  initial release
// ============================================================================
module user_core_irq_cond #(
    parameter int                 NUM_IRQ  = 2,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0,
    parameter bit                 IRQ_SYNC = 1'b1
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    input  wire logic [NUM_IRQ-1:0] irq_in,
    output logic      [NUM_IRQ-1:0] irq_out
);

    logic [NUM_IRQ-1:0] irq_s;

    generate
        if (IRQ_SYNC) begin : g_sync
            logic [NUM_IRQ-1:0] sync_meta;
            logic [NUM_IRQ-1:0] sync_out;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_meta <= '0;
                    sync_out  <= '0;
                end else begin
                    sync_meta <= irq_in;
                    sync_out  <= sync_meta;
                end
            end

            assign irq_s = sync_out;
        end else begin : g_nosync
            assign irq_s = irq_in;
        end
    endgenerate

    genvar k;
    generate
        for (k = 0; k < NUM_IRQ; k++) begin : g_line
            if (IRQ_EDGE[k]) begin : g_edge
                // Previous sample; a held-high line yields a single pulse.
                logic s_prev;

                always_ff @(posedge clk_i) begin
                    if (rst_i) begin
                        s_prev <= 1'b0;
                    end else begin
                        s_prev <= irq_s[k];
                    end
                end

                assign irq_out[k] = irq_s[k] & ~s_prev;
            end else begin : g_level
                assign irq_out[k] = irq_s[k];
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/user_core_nmi_shim.sv
`default_nettype none
// ============================================================================
//  Module   : user_core_nmi_shim
//  Purpose  : Shim between a user core memory port and the SoC NMI master
//             port. Registers each request, word-aligns the address,
//             enforces an address window and a bus timeout (both answered
//             with an access fault) and conditions a slice of irq_i into
//             the core interrupt lines.
//  Ports    : clk_i        - clock
//             rst_i        - synchronous active-high reset
//             core         - core request port (slave modport)
//             core_fault_o - access fault, qualified by core.ready
//             nmi          - SoC bus port (master modport)
//             irq_i        - SoC interrupt vector
//             irq_o        - conditioned core interrupts
//             fault_cnt_o  - saturating fault count since reset
//  Revision : 1.0  initial release
// ============================================================================
module user_core_nmi_shim
    import user_core_shim_pkg::*;
#(
    parameter logic [31:0]        ADDR_LO     = 32'h0000_0000,
    parameter logic [31:0]        ADDR_HI     = 32'hFFFF_FFFF,
    parameter int unsigned        TIMEOUT_CYC = 256,
    parameter logic [31:0]        FAULT_RDATA = 32'hDEAD_BEEF,
    parameter int                 NUM_IRQ     = 2,
    parameter int                 IRQ_BASE    = 0,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE    = '0,
    parameter bit                 IRQ_SYNC    = 1'b1
) (
    input  wire logic                    clk_i,
    input  wire logic                    rst_i,
    user_core_nmi_shim_if.slave          core,
    output logic                         core_fault_o,
    user_core_nmi_shim_if.master         nmi,
    input  wire logic [31:0]             irq_i,
    output logic      [NUM_IRQ-1:0]      irq_o,
    output logic      [FAULT_CNT_W-1:0]  fault_cnt_o
);

    localparam int          TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit          TMO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    shim_state_e             state;
    shim_state_e             state_next;
    logic                    accept;
    logic                    lo_ok;
    logic                    hi_ok;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [NMI_AW-1:0]       req_addr;
    logic [NMI_SW-1:0]       req_wstrb;
    logic [NMI_DW-1:0]       req_wdata;
    logic                    rsp_ready;
    logic                    rsp_fault;
    logic [NMI_DW-1:0]       rsp_rdata;
    logic [FAULT_CNT_W-1:0]  fault_cnt;
    logic                    unused_bits;

    // Window bounds at the extremes of the address space are always met;
    // skip the comparator there instead of building a constant compare.
    generate
        if (ADDR_LO == 32'h0000_0000) begin : g_lo_open
            assign lo_ok = 1'b1;
        end else begin : g_lo_chk
            assign lo_ok = (core.addr >= ADDR_LO);
        end
        if (ADDR_HI == 32'hFFFF_FFFF) begin : g_hi_open
            assign hi_ok = 1'b1;
        end else begin : g_hi_chk
            assign hi_ok = (core.addr <= ADDR_HI);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (core.valid) begin
                    if (lo_ok && hi_ok) begin
                        state_next = REQ;
                        accept     = 1'b1;
                    end else begin
                        state_next = FAULT;
                    end
                end
            end
            REQ: begin
                // Ready is tested first so a completion on the last
                // allowed cycle still counts as a normal response.
                if (nmi.ready) begin
                    state_next = RESP;
                end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                    state_next = FAULT;
                end
            end
            RESP:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, datapath and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            req_addr  <= '0;
            req_wstrb <= '0;
            req_wdata <= '0;
            rsp_ready <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
            fault_cnt <= '0;
        end else begin
            state <= state_next;

            if (accept) begin
                req_addr  <= word_align(core.addr);
                req_wstrb <= core.wstrb;
                req_wdata <= core.wdata;
            end

            // Counts cycles spent waiting; any exit from REQ clears it.
            if ((state == REQ) && (state_next == REQ)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end

            // Responses are computed from the state being entered so the
            // strobe lines up with the RESP/FAULT cycle.
            rsp_ready <= (state_next == RESP) || (state_next == FAULT);
            rsp_fault <= (state_next == FAULT);
            if (state_next == RESP) begin
                rsp_rdata <= nmi.rdata;
            end else if (state_next == FAULT) begin
                rsp_rdata <= FAULT_RDATA;
            end else begin
                rsp_rdata <= '0;
            end

            if ((state_next == FAULT) && (fault_cnt != '1)) begin
                fault_cnt <= fault_cnt + 1'b1;
            end
        end
    end

    assign nmi.valid    = (state == REQ);
    assign nmi.addr     = req_addr;
    assign nmi.wstrb    = req_wstrb;
    assign nmi.wdata    = req_wdata;

    assign core.ready   = rsp_ready;
    assign core.rdata   = rsp_rdata;
    assign core_fault_o = rsp_fault;
    assign fault_cnt_o  = fault_cnt;

    // ------------------------------------------------------------------
    // Interrupt conditioning on the selected slice of irq_i
    // ------------------------------------------------------------------
    user_core_irq_cond #(
        .NUM_IRQ  (NUM_IRQ),
        .IRQ_EDGE (IRQ_EDGE),
        .IRQ_SYNC (IRQ_SYNC)
    ) u_irq_cond (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .irq_in  (irq_i[IRQ_BASE +: NUM_IRQ]),
        .irq_out (irq_o)
    );

    // Bits outside the selected slice and the byte offset are intentionally
    // ignored.
    assign unused_bits = ^{irq_i, core.addr[1:0]};

endmodule
`default_nettype wire
